// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader connects through the slave modport; the byte source uses master.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_waddr, imem_wdata
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for the instruction memory; holds the core until the image is in.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FIN,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      widx_q;
  logic [1:0]            bidx_q;
  logic [23:0]           asm_q;
  logic                  s_ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic             acc_c;
  logic             start_acc_c;
  logic [CNT_W-1:0] n_c;
  logic             last_word_c;

  assign bus.s_ready    = s_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

  // Next-state decode; the outputs below are registered from state_d.
  always_comb begin
    state_d     = state_q;
    acc_c       = bus.s_valid && s_ready_q;
    n_c         = {bus.s_data, len_lo_q};
    last_word_c = (widx_q == (cnt_q - CNT_W'(1)));
    start_acc_c = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_acc_c) state_d = S_LEN_LO;
      S_LEN_LO: if (acc_c) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (acc_c) begin
          if ({1'b0, n_c} > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (n_c != '0) begin
            state_d = S_DATA;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_DATA: if (acc_c && (bidx_q == 2'd3) && last_word_c) state_d = S_FIN;
      S_FIN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = S_CSUM;
`else
        state_d = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (acc_c) state_d = (bus.s_data == csum_q) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_lo_q  <= '0;
      cnt_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      asm_q     <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_d == S_CSUM)
`endif
                   ;
      busy      <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA)
                   || (state_d == S_FIN)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_d == S_CSUM)
`endif
                   ;
      done      <= (state_d == S_DONE);
      err       <= (state_d == S_ERR);
      cpu_hold  <= (state_d != S_DONE);
      we_q      <= 1'b0;

      // Every new load restarts at word 0 with a clean partial word.
      if (start_acc_c) begin
        widx_q <= '0;
        bidx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= '0;
`endif
      end

      if (acc_c && (state_q == S_LEN_LO)) len_lo_q <= bus.s_data;
      if (acc_c && (state_q == S_LEN_HI)) cnt_q    <= n_c;

      // Bytes arrive LSB first; the 4th byte completes the word and fires the write.
      if (acc_c && (state_q == S_DATA)) begin
        bidx_q <= bidx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ bus.s_data;
`endif
        if (bidx_q == 2'd3) begin
          we_q    <= 1'b1;
          waddr_q <= ADDR_WIDTH'(widx_q);
          wdata_q <= {bus.s_data, asm_q};
          widx_q  <= widx_q + CNT_W'(1);
        end else begin
          asm_q <= {bus.s_data, asm_q[23:8]};
        end
      end
    end
  end

endmodule
